// File: rtl/mips_muldiv_ctrl.sv
// HI/LO owner and iterative MULT/MULTU/DIV/DIVU engine for the execute stage.
// One shift-add or restoring-divide step per cycle, plus the HI/LO interlock.
module mips_muldiv_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  pipeline_flush_i,
  input  logic                  valid_i,
  input  logic [5:0]            funct_i,
  input  logic [DATA_WIDTH-1:0] rs_val_i,
  input  logic [DATA_WIDTH-1:0] rt_val_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic [DATA_WIDTH-1:0] mf_result_o
);
  localparam int W = DATA_WIDTH;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic                 div_q, div_d;

  logic           is_mul, is_div, is_hl, issue, sgn, last;
  logic [W-1:0]   rs_mag, rt_mag, q_fix, r_fix;
  logic [W:0]     msum, dtop, dtrial;
  logic [2*W-1:0] p_fix;

  always_comb begin
    is_mul = (funct_i == F_MULT) | (funct_i == F_MULTU);
    is_div = (funct_i == F_DIV)  | (funct_i == F_DIVU);
    is_hl  = (funct_i == F_MFHI) | (funct_i == F_MTHI) |
             (funct_i == F_MFLO) | (funct_i == F_MTLO);
    sgn    = (funct_i == F_MULT) | (funct_i == F_DIV);
    busy_o  = (state_q != S_IDLE);
    stall_o = busy_o & valid_i & (is_mul | is_div | is_hl);
    issue   = valid_i & ~stall_o & ~pipeline_flush_i;
    rs_mag = (sgn & rs_val_i[W-1]) ? -rs_val_i : rs_val_i;
    rt_mag = (sgn & rt_val_i[W-1]) ? -rt_val_i : rt_val_i;
    last   = (cnt_q == CNT_WIDTH'(W-1));
    // Multiply: acc = {partial, multiplier}, add then shift right
    msum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    // Divide: acc = {remainder, dividend/quotient}, shift left then trial subtract
    dtop   = acc_q[2*W-1:W-1];
    dtrial = dtop - {1'b0, a_q};
    p_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    q_fix  = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    r_fix  = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_d   = div_q;
    if (pipeline_flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue & (is_mul | is_div)) begin
            cnt_d = '0;
            sa_d  = sgn & rs_val_i[W-1];
            sb_d  = sgn & rt_val_i[W-1];
            div_d = is_div;
            if (is_mul) begin
              a_d     = rs_mag;
              acc_d   = {{W{1'b0}}, rt_mag};
              state_d = S_MUL;
            end else if (rt_val_i == '0) begin
              // Zero signs so FIX passes {rs, all ones} through untouched
              sa_d    = 1'b0;
              sb_d    = 1'b0;
              acc_d   = {rs_val_i, {W{1'b1}}};
              state_d = S_FIX;
            end else begin
              a_d     = rt_mag;
              acc_d   = {{W{1'b0}}, rs_mag};
              state_d = S_DIV;
            end
          end else if (issue & (funct_i == F_MTHI)) begin
            hi_d = rs_val_i;
          end else if (issue & (funct_i == F_MTLO)) begin
            lo_d = rs_val_i;
          end
        end
        S_MUL: begin
          acc_d = {msum, acc_q[W-1:1]};
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last) state_d = S_FIX;
        end
        S_DIV: begin
          if (!dtrial[W]) acc_d = {dtrial[W-1:0], acc_q[W-2:0], 1'b1};
          else            acc_d = {dtop[W-1:0], acc_q[W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last) state_d = S_FIX;
        end
        default: begin
          hi_d    = div_q ? r_fix : p_fix[2*W-1:W];
          lo_d    = div_q ? q_fix : p_fix[W-1:0];
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
    end
  end

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign mf_result_o = (funct_i == F_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Randomised self-checking bench for mips_muldiv_ctrl.
// Reference model uses plain 64-bit arithmetic on HI/LO.
module tb_mips_muldiv_ctrl;
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11;
  localparam logic [5:0] MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19;
  localparam logic [5:0] DIV = 6'h1A, DIVU = 6'h1B;
  localparam logic [5:0] ADDU = 6'h21;

  logic        clk = 0;
  logic        rst_i = 0;
  logic        flush = 0;
  logic        valid = 0;
  logic [5:0]  funct = 0;
  logic [31:0] rs = 0, rt = 0;
  logic        stall_o, busy_o;
  logic [31:0] hi_o, lo_o, mf_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mh = 0, ml = 0;

  mips_muldiv_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst_i(rst_i), .pipeline_flush_i(flush),
    .valid_i(valid), .funct_i(funct),
    .rs_val_i(rs), .rt_val_i(rt),
    .stall_o(stall_o), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o), .mf_result_o(mf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [5:0] f,
      input logic [31:0] a, input logic [31:0] b,
      output logic [31:0] h, output logic [31:0] l);
    longint x, y, q, r;
    logic [63:0] p;
    logic s;
    s = (f == MULT) || (f == DIV);
    x = s ? longint'($signed(a)) : longint'({32'b0, a});
    y = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (f == MULT || f == MULTU) begin
      p = 64'(x * y);
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else begin
      q = x / y;
      r = x % y;
      p = 64'(q);
      l = p[31:0];
      p = 64'(r);
      h = p[31:0];
    end
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [31:0] a,
      input logic [31:0] b, input string nm);
    logic [31:0] eh, el;
    int cyc, ecyc;
    model(f, a, b, eh, el);
    ecyc = ((f == DIV || f == DIVU) && b == 0) ? 1 : 33;
    valid = 1; funct = f; rs = a; rt = b;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_stall got=%b want=0", nm, stall_o);
    end
    tick();
    valid = 0; funct = 6'($urandom); rs = $urandom; rt = $urandom;
    cyc = 0;
    while (busy_o && cyc < 100) begin
      cyc++;
      tick();
    end
    n_cmp++;
    if (cyc != ecyc) begin
      n_err++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", nm, cyc, ecyc);
    end
    n_cmp++;
    if (hi_o !== eh || lo_o !== el) begin
      n_err++;
      $display("FAIL %s f=%h a=%h b=%h hi/lo got=%h/%h want=%h/%h",
               nm, f, a, b, hi_o, lo_o, eh, el);
    end
    mh = eh; ml = el;
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] v);
    valid = 1; funct = f; rs = v;
    tick();
    valid = 0;
    if (f == MTHI) mh = v; else ml = v;
  endtask

  task automatic test_reset();
    #1 rst_i = 1;
    #1;
    n_cmp++;
    if (busy_o !== 0 || stall_o !== 0 || hi_o !== 0 || lo_o !== 0) begin
      n_err++;
      $display("FAIL reset got busy=%b stall=%b hi=%h lo=%h want 0",
               busy_o, stall_o, hi_o, lo_o);
    end
    tick();
    rst_i = 0;
  endtask

  task automatic test_directed();
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    run_op(MULT, 32'h8000_0000, 32'h8000_0000, "mult_minsq");
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    run_op(DIVU, 32'd100, 32'd7, "divu_100by7");
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(DIVU, 32'h1234, 32'd0, "divu_zero");
    run_op(DIV, 32'hFFFF_0000, 32'd0, "div_zero");
  endtask

  task automatic test_random();
    logic [5:0] f;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      run_op(f, a, b, "random");
    end
  endtask

  task automatic test_mt_mf();
    logic [31:0] v1, v2;
    v1 = $urandom; v2 = $urandom;
    mt(MTHI, v1);
    mt(MTLO, v2);
    valid = 1; funct = MFHI;
    #1;
    n_cmp++;
    if (hi_o !== v1 || mf_o !== v1) begin
      n_err++;
      $display("FAIL mfhi got hi=%h mf=%h want=%h", hi_o, mf_o, v1);
    end
    funct = MFLO;
    #1;
    n_cmp++;
    if (lo_o !== v2 || mf_o !== v2) begin
      n_err++;
      $display("FAIL mflo got lo=%h mf=%h want=%h", lo_o, mf_o, v2);
    end
    tick();
    valid = 0;
  endtask

  task automatic test_interlock();
    int n;
    valid = 1; funct = MULT; rs = 6; rt = 7;
    tick();
    funct = ADDU; rs = $urandom; rt = $urandom;
    #1;
    n_cmp++;
    if (stall_o !== 0 || busy_o !== 1) begin
      n_err++;
      $display("FAIL addu_while_busy stall=%b busy=%b want 0/1",
               stall_o, busy_o);
    end
    tick();
    funct = MFLO;
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 32) begin
      n_err++;
      $display("FAIL mflo_stall_cycles got=%0d want=32", n);
    end
    n_cmp++;
    if (mf_o !== 32'd42) begin
      n_err++;
      $display("FAIL mflo_result got=%h want=%h", mf_o, 32'd42);
    end
    tick();
    valid = 1; funct = MULT; rs = 32'hFFFF_FFFE; rt = 3;
    tick();
    funct = MTLO; rs = 32'h55;
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      n++;
      tick();
    end
    tick();
    valid = 0;
    n_cmp++;
    if (lo_o !== 32'h55 || hi_o !== 32'hFFFF_FFFF || n != 33) begin
      n_err++;
      $display("FAIL mtlo_busy got lo=%h hi=%h n=%0d want 55/ffffffff/33",
               lo_o, hi_o, n);
    end
    mh = hi_o; ml = 32'h55;
  endtask

  task automatic test_back_to_back();
    logic [31:0] eh, el;
    int n;
    model(MULTU, 32'd1000, 32'd3000, eh, el);
    valid = 1; funct = MULTU; rs = 32'd1000; rt = 32'd3000;
    tick();
    funct = DIVU; rs = 32'd77; rt = 32'd0;
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      n++;
      tick();
    end
    n_cmp++;
    if (busy_o !== 0 || hi_o !== eh || lo_o !== el) begin
      n_err++;
      $display("FAIL b2b_first got busy=%b hi/lo=%h/%h want 0 %h/%h",
               busy_o, hi_o, lo_o, eh, el);
    end
    tick();
    valid = 0;
    n_cmp++;
    if (busy_o !== 1) begin
      n_err++;
      $display("FAIL b2b_accept got busy=%b want=1", busy_o);
    end
    tick();
    n_cmp++;
    if (busy_o !== 0 || hi_o !== 32'd77 || lo_o !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL b2b_second got busy=%b hi/lo=%h/%h want 0 4d/ffffffff",
               busy_o, hi_o, lo_o);
    end
    mh = hi_o; ml = lo_o;
  endtask

  task automatic test_flush();
    mt(MTHI, 32'hA);
    mt(MTLO, 32'hB);
    valid = 1; funct = DIV; rs = $urandom; rt = 32'd3;
    tick();
    valid = 0;
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    n_cmp++;
    if (busy_o !== 0 || hi_o !== 32'hA || lo_o !== 32'hB) begin
      n_err++;
      $display("FAIL flush_mid got busy=%b hi/lo=%h/%h want 0 a/b",
               busy_o, hi_o, lo_o);
    end
    valid = 1; funct = MULTU; rs = 32'd9; rt = 32'd9;
    tick();
    valid = 0;
    repeat (32) tick();
    flush = 1;
    tick();
    flush = 0;
    n_cmp++;
    if (busy_o !== 0 || hi_o !== 32'hA || lo_o !== 32'hB) begin
      n_err++;
      $display("FAIL flush_fix got busy=%b hi/lo=%h/%h want 0 a/b",
               busy_o, hi_o, lo_o);
    end
    valid = 1; funct = MULT; rs = 2; rt = 2; flush = 1;
    tick();
    funct = MTHI; rs = 32'h99;
    tick();
    valid = 0; flush = 0;
    n_cmp++;
    if (busy_o !== 0 || hi_o !== 32'hA) begin
      n_err++;
      $display("FAIL flush_accept got busy=%b hi=%h want 0 a", busy_o, hi_o);
    end
  endtask

  task automatic test_reset_mid();
    run_op(MULTU, 32'hFFFF_FFFF, 32'h3, "pre_reset");
    valid = 1; funct = MULT; rs = $urandom; rt = $urandom;
    tick();
    valid = 0;
    repeat (5) tick();
    #2 rst_i = 1;
    #1;
    n_cmp++;
    if (busy_o !== 0 || hi_o !== 0 || lo_o !== 0) begin
      n_err++;
      $display("FAIL reset_mid got busy=%b hi=%h lo=%h want 0",
               busy_o, hi_o, lo_o);
    end
    tick();
    rst_i = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mt_mf();
    test_interlock();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
